// File: rtl/storage_write_sequencer.sv
// storage_write_sequencer: valid/ready command front end that writes a byte register,
// verifies each write by read-back with bounded retries, and keeps saturating status counters.
module storage_write_sequencer #(
    parameter int WIDTH     = 8,
    parameter int RETRY_MAX = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_error,
    output logic             write_enable,
    output logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] stat_writes,
    output logic [CNT_W-1:0] stat_errors
);
    typedef enum logic [2:0] {IDLE, WRITE, VERIFY, READ, RESP} state_t;
    localparam logic [2:0] RMAX = 3'(RETRY_MAX);
    state_t state, state_nx;
    logic run;
    logic [2:0] retry;
    logic match, can_retry, accept, done;
    // run keeps cmd_ready low while in reset and rises after the first edge out of reset
    assign cmd_ready    = run && state == IDLE;
    assign write_enable = state == WRITE;
    assign rsp_valid    = state == RESP;
    assign match        = data_out == data_in;
    assign can_retry    = retry < RMAX;
    assign accept       = cmd_valid && cmd_ready;
    assign done         = match || !can_retry;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (cmd_write ? WRITE : READ) : IDLE;
            WRITE:   state_nx = VERIFY;
            VERIFY:  state_nx = done ? RESP : WRITE;
            READ:    state_nx = RESP;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            run         <= 1'b0;
            retry       <= '0;
            data_in     <= '0;
            rsp_data    <= '0;
            rsp_error   <= 1'b0;
            stat_writes <= '0;
            stat_errors <= '0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
            if (accept && cmd_write) begin
                data_in <= cmd_data;
                retry   <= '0;
            end
            if (state == VERIFY) begin
                if (done) begin
                    rsp_data  <= data_out;
                    rsp_error <= !match;
                end else begin
                    retry <= retry + 3'd1;
                end
                if (match && stat_writes != '1)
                    stat_writes <= stat_writes + CNT_W'(1);
                if (!match && !can_retry && stat_errors != '1)
                    stat_errors <= stat_errors + CNT_W'(1);
            end
            if (state == READ) begin
                rsp_data  <= data_out;
                rsp_error <= 1'b0;
            end
        end
    end
endmodule

// File: doc/storage_write_sequencer.md
Name: storage_write_sequencer

Overview:
- Initiator side for a single-register byte storage port: `write_enable`, `data_in`, `data_out`; the storage captures on the rising edge of `clk` while `write_enable` is high.
- Accepts write and read commands on a valid/ready command channel.
- Drives the storage port and verifies each write by read-back, retrying on mismatch.
- Returns one response per command on a valid/ready response channel; keeps saturating status counters.

Parameters:
- WIDTH, 8, data width of the storage port and command/response data.
- RETRY_MAX, 2, extra write attempts after a failed read-back verify (0..7).
- CNT_W, 16, width of the status counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_data  in  WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  read value, or read-back value for writes.
- rsp_error  out  1  write verify failed after all retries.
- write_enable  out  1  to the storage write enable.
- data_in  out  WIDTH  to the storage data input.
- data_out  in  WIDTH  from the storage, valid the cycle after the capturing edge.
- stat_writes  out  CNT_W  count of successfully verified writes, saturating.
- stat_errors  out  CNT_W  count of writes ending in rsp_error, saturating.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE immediately.
  - All outputs go to 0: cmd_ready, rsp_valid, rsp_data, rsp_error, write_enable, data_in, both counters, and the retry counter.
  - cmd_ready rises in the first cycle after rst_n is released.
- Reset mid-operation:
  - write_enable drops immediately.
  - The in-flight command is discarded and no response is issued.
- All outputs are decoded from registers only. There is no combinational path from cmd_* or rsp_ready to any output.
- cmd_ready = (state == IDLE). A command is accepted on a rising edge with cmd_valid && cmd_ready.
- On accept, cmd_data is latched into data_in; data_in holds that value until the next accepted write. Reads do not change data_in.
- FSM states:
  - IDLE: on accepting a write → WRITE, retry counter cleared. On accepting a read → READ.
  - WRITE: write_enable = 1 for exactly this one cycle → VERIFY.
  - VERIFY: write_enable = 0; compare data_out with data_in.
    - Match → RESP with rsp_error = 0; stat_writes increments.
    - Mismatch and retry count < RETRY_MAX → retry count increments → WRITE.
    - Mismatch and retry count = RETRY_MAX → RESP with rsp_error = 1; stat_errors increments.
    - In both RESP cases, rsp_data = data_out as sampled in VERIFY.
  - READ: sample data_out into rsp_data; rsp_error = 0 → RESP. write_enable stays 0.
  - RESP: rsp_valid = 1. rsp_data and rsp_error are held stable until rsp_ready is high on an edge → IDLE.
- Latency, with command accepted at edge 0:
  - Write: write_enable high in cycle 1. Verify in cycle 2. rsp_valid from cycle 3. Each retry adds 2 cycles.
  - Read: sample in cycle 1. rsp_valid from cycle 2.
- Throughput:
  - Exactly one command is outstanding; no new command is accepted while in RESP.
  - After the response handshake edge, cmd_ready is 1 in the next cycle.
- Counters saturate at all-ones and do not wrap. Both counters are cleared only by reset.
- rsp_valid never deasserts without a handshake. rsp_ready while rsp_valid = 0 is ignored.

Test Plan:
- Reset, then write 0x55 with an ideal storage model:
  - write_enable high exactly one cycle with data_in = 0x55.
  - rsp_valid in cycle 3; rsp_data = 0x55, rsp_error = 0; stat_writes = 1.
- Write 0xAA, then read:
  - No write_enable pulse during the read.
  - rsp_valid 2 cycles after accept; rsp_data = 0xAA, rsp_error = 0.
- Storage model with data_out bit 0 stuck at 0, write 0xFF, RETRY_MAX = 2:
  - Three write_enable pulses, 2 cycles apart.
  - rsp_error = 1, rsp_data = 0xFE; stat_errors = 1, stat_writes unchanged.
- Hold rsp_ready low for 5 cycles after a read of 0xAA, with cmd_valid held high:
  - rsp_valid, rsp_data and rsp_error are stable throughout; cmd_ready = 0.
  - Accept occurs the cycle after the rsp handshake.
- Assert rst_n low during WRITE of 0xFF:
  - write_enable and data_in go to 0 asynchronously; no response is issued.
  - cmd_ready = 1 in the first cycle after release; counters read 0.
- Back-to-back writes 0x55, 0xAA, 0xFF with cmd_valid and rsp_ready held high:
  - Three responses with rsp_data matching, each 4 cycles apart.
  - Final stat_writes = 3, stat_errors = 0.
